sobol_gen: RTL and testbench

One-dimensional Sobol low-discrepancy point generator; the stage directly upstream of the inverse-normal-CDF unit. It produces u in [0,1) with FRAC fractional bits, one point per cycle. Points are produced by Gray-code (Antonov–Saleev) updates over a loadable set of 32 direction numbers. A downstream valid/ready handshake lets the path scheduler stall it. One instance serves one QMC dimension; direction numbers are loaded per dimension before a run.

---
 rtl/sobol_gen_pkg.sv | 27 ++
 rtl/sobol_gen_if.sv | 33 +++
 rtl/sobol_gen_ctz.sv | 25 ++
 rtl/sobol_gen.sv | 142 ++++++++++++++
 tb/tb_sobol_gen.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sobol_gen_pkg.sv
// -----------------------------------------------------------------------------
// qmc_pkg
// Shared types and constants for the one-dimensional Sobol point generator.
//   SOBOL_BITS    : width of the Sobol state and of every direction number
//   sobol_dir_t   : one MSB-aligned direction number
//   sobol_state_e : generator FSM states
//   default_dir() : power-on direction number for index k (van der Corput)
// -----------------------------------------------------------------------------
package qmc_pkg;

  localparam int SOBOL_BITS = 32;

  typedef logic [SOBOL_BITS-1:0] sobol_dir_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sobol_state_e;

  // v_k = 1 << (31-k): with these the generator reproduces the base-2
  // van der Corput sequence, a usable default for any dimension.
  function automatic sobol_dir_t default_dir(input logic [4:0] k);
    return sobol_dir_t'(32'h8000_0000) >> k;
  endfunction

endpackage

// File: rtl/sobol_gen_if.sv
// -----------------------------------------------------------------------------
// sobol_gen_if
// Downstream point stream of the Sobol generator (valid/ready handshake).
//   out_valid : u_out/idx_out carry a point (driven by master)
//   out_ready : consumer accepts the point this cycle (driven by slave)
//   u_out     : point in [0,1), unsigned fixed point, integer bits zero
//   idx_out   : Sobol index n of u_out
// -----------------------------------------------------------------------------
interface sobol_gen_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 20
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] u_out;
  logic [CNT_W-1:0] idx_out;

  modport master (
    output out_valid,
    output u_out,
    output idx_out,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  u_out,
    input  idx_out,
    output out_ready
  );

endinterface

// File: rtl/sobol_gen_ctz.sv
// -----------------------------------------------------------------------------
// sobol_ctz
// Combinational trailing-ones encoder: returns the index of the lowest zero bit
// of a 32-bit word.
//   word_i : input word
//   idx_o  : index (0..31) of the lowest zero bit; 0 if the word is all ones
// -----------------------------------------------------------------------------
module sobol_ctz
  import qmc_pkg::*;
(
  input  sobol_dir_t  word_i,
  output logic [4:0]  idx_o
);

  // Scanning from the top down lets the lowest zero bit win as the last write.
  always_comb begin
    idx_o = '0;
    for (int i = SOBOL_BITS - 1; i >= 0; i--) begin
      if (!word_i[i]) begin
        idx_o = 5'(i);
      end
    end
  end

endmodule

// File: rtl/sobol_gen.sv
// -----------------------------------------------------------------------------
// sobol_gen
// One-dimensional Sobol point generator (Antonov-Saleev Gray-code update),
// one point per cycle, stallable by the downstream handshake.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begin a run (sampled only in IDLE)
//   num_points  : points to emit this run, latched on start
//   dir_we      : direction-number write strobe (IDLE only)
//   dir_addr    : direction index k
//   dir_data    : direction number v_k, MSB-aligned
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse at end of run
//   out_if      : point stream (out_valid/out_ready/u_out/idx_out)
// Build option SOBOL_SKIP0_EN: runs start at n=1 so the point u=0 is never
// emitted; num_points still counts emitted points.
// -----------------------------------------------------------------------------
module sobol_gen
  import qmc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int CNT_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_points,
  input  logic              dir_we,
  input  logic [4:0]        dir_addr,
  input  logic [31:0]       dir_data,
  output logic              busy,
  output logic              done,
  sobol_gen_if.master       out_if
);

  sobol_state_e     state_q, state_d;
  sobol_dir_t       x_q, x_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  sobol_dir_t       dir_q [SOBOL_BITS];
  sobol_dir_t       dir_d [SOBOL_BITS];

  sobol_dir_t       nWide;
  logic [4:0]       ctzIdx;

  // c = lowest zero bit of the index of the point being retired.
  assign nWide = sobol_dir_t'(n_q);

  sobol_ctz u_ctz (
    .word_i (nWide),
    .idx_o  (ctzIdx)
  );

  // State register; reset also restores the van der Corput directions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < SOBOL_BITS; k++) begin
        dir_q[k] <= default_dir(5'(k));
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic. Directions are only writable in IDLE so a run always
  // sees one consistent set; a run advances only on an accepted point.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    n_d     = n_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    dir_d   = dir_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (dir_we) begin
          dir_d[dir_addr] = dir_data;
        end
        if (start) begin
          if (num_points == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            rem_d   = num_points;
`ifdef SOBOL_SKIP0_EN
            // x_1 = x_0 ^ v[ctz(0)] = v[0]
            x_d     = dir_q[0];
            n_d     = CNT_W'(1);
`else
            x_d     = '0;
            n_d     = '0;
`endif
          end
        end
      end

      RUN: begin
        if (valid_q && out_if.out_ready) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            x_d     = x_q ^ dir_q[ctzIdx];
            n_d     = n_q + CNT_W'(1);
            rem_d   = rem_q - CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // All outputs are decoded straight from registers.
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign out_if.out_valid = valid_q;
  assign out_if.u_out     = WIDTH'(x_q[31 -: FRAC]);
  assign out_if.idx_out   = n_q;

endmodule

// File: tb/tb_sobol_gen.sv
// -----------------------------------------------------------------------------
// tb_sobol_gen
// Self-checking bench for sobol_gen (WIDTH=32, FRAC=16, CNT_W=20). Follows the
// SOBOL_SKIP0_EN build option through the expected-value selection.
// -----------------------------------------------------------------------------
module tb_sobol_gen;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int CNT_W = 20;

`ifdef SOBOL_SKIP0_EN
  localparam int BASE = 1;
  // Points after loading v0 = 0xFFFFFFFF: x1 = v0, x2 = v0 ^ v1
  localparam logic [31:0] DIR_E0 = 32'h0000_FFFF;
  localparam logic [31:0] DIR_E1 = 32'h0000_BFFF;
`else
  localparam int BASE = 0;
  // Points after loading v0 = 0xFFFFFFFF: x0 = 0, x1 = v0
  localparam logic [31:0] DIR_E0 = 32'h0000_0000;
  localparam logic [31:0] DIR_E1 = 32'h0000_FFFF;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] numPoints;
  logic             dirWe;
  logic [4:0]       dirAddr;
  logic [31:0]      dirData;
  logic             busy;
  logic             done;

  sobol_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) busIf ();

  sobol_gen #(.WIDTH(WIDTH), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_points (numPoints),
    .dir_we     (dirWe),
    .dir_addr   (dirAddr),
    .dir_data   (dirData),
    .busy       (busy),
    .done       (done),
    .out_if     (busIf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-direction u_out for n = 0..5 (Gray codes 0,1,11,10,110,111 over
  // v0=0x8000, v1=0x4000, v2=0x2000 in the top 16 bits).
  logic [31:0] seqU [6];

  typedef struct {
    logic             st;
    logic             rdy;
    logic             expValid;
    logic [31:0]      expU;
    logic [CNT_W-1:0] expIdx;
    logic             expBusy;
    logic             expDone;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic st, input logic rdy, input logic v,
                        input logic [31:0] u, input int idx,
                        input logic b, input logic d);
    vec_t e;
    e.st = st; e.rdy = rdy; e.expValid = v; e.expU = u;
    e.expIdx = CNT_W'(idx); e.expBusy = b; e.expDone = d;
    vecs.push_back(e);
  endtask

  // Five-point run; stallCycles holds out_ready low on the second point.
  // A start pulse mid-run must be ignored.
  task automatic buildRun(input int stallCycles);
    vecs.delete();
    for (int p = 0; p < 5; p++) begin
      if (p == 1) begin
        for (int s = 0; s < stallCycles; s++) begin
          addVec(1'b0, 1'b0, 1'b1, seqU[BASE+p], BASE + p, 1'b1, 1'b0);
        end
      end
      addVec(p == 2, 1'b1, 1'b1, seqU[BASE+p], BASE + p, 1'b1, 1'b0);
    end
    addVec(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b1, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
  endtask

  // Called right after the start pulse has been set up on a falling edge.
  task automatic applyStimulus(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start          = vecs[i].st;
      busIf.out_ready = vecs[i].rdy;
      checkOutput($sformatf("%s[%0d] valid", tag, i), 32'(busIf.out_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(vecs[i].expDone));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("%s[%0d] u", tag, i), 32'(busIf.u_out), vecs[i].expU);
        checkOutput($sformatf("%s[%0d] idx", tag, i), 32'(busIf.idx_out), 32'(vecs[i].expIdx));
      end
    end
    start = 1'b0;
  endtask

  // Two-point run with a bounded wait for done; optionally tries a direction
  // write while the run is active.
  task automatic runTwo(input string tag, input logic [31:0] e0,
                        input logic [31:0] e1, input logic weDuringRun);
    int k;
    @(negedge clk);
    dirWe = 1'b0; start = 1'b1; numPoints = CNT_W'(2); busIf.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (weDuringRun) begin
      dirWe = 1'b1; dirAddr = 5'd0; dirData = 32'h0;
    end
    checkOutput({tag, " p0 valid"}, 32'(busIf.out_valid), 32'h1);
    checkOutput({tag, " p0 u"}, 32'(busIf.u_out), e0);
    @(negedge clk);
    dirWe = 1'b0;
    checkOutput({tag, " p1 valid"}, 32'(busIf.out_valid), 32'h1);
    checkOutput({tag, " p1 u"}, 32'(busIf.u_out), e1);
    k = 0;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, " done seen"}, 32'(done), 32'h1);
    @(negedge clk);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    seqU[0] = 32'h0000_0000;
    seqU[1] = 32'h0000_8000;
    seqU[2] = 32'h0000_C000;
    seqU[3] = 32'h0000_4000;
    seqU[4] = 32'h0000_6000;
    seqU[5] = 32'h0000_E000;

    rst_n = 1'b0; start = 1'b0; numPoints = '0; dirWe = 1'b0;
    dirAddr = '0; dirData = '0; busIf.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset valid", 32'(busIf.out_valid), 32'h0);
    checkOutput("reset u", 32'(busIf.u_out), 32'h0);
    checkOutput("reset idx", 32'(busIf.idx_out), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // Unstalled run, start pulse mid-run ignored
    @(negedge clk);
    start = 1'b1; numPoints = CNT_W'(5);
    buildRun(0);
    applyStimulus("run");

    // Same run with a 3-cycle stall on the second point
    @(negedge clk);
    start = 1'b1; numPoints = CNT_W'(5);
    buildRun(3);
    applyStimulus("stall");

    // num_points = 0: done pulse only
    @(negedge clk);
    start = 1'b1; numPoints = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero done", 32'(done), 32'h1);
    checkOutput("zero valid", 32'(busIf.out_valid), 32'h0);
    checkOutput("zero busy", 32'(busy), 32'h1);
    @(negedge clk);
    checkOutput("zero done low", 32'(done), 32'h0);
    checkOutput("zero busy low", 32'(busy), 32'h0);
    checkOutput("zero valid low", 32'(busIf.out_valid), 32'h0);

    // Direction load in IDLE, write during RUN ignored, rerun unchanged
    @(negedge clk);
    dirWe = 1'b1; dirAddr = 5'd0; dirData = 32'hFFFF_FFFF;
    runTwo("dirload", DIR_E0, DIR_E1, 1'b1);
    runTwo("dirrerun", DIR_E0, DIR_E1, 1'b0);

    // Reset mid-run restores IDLE and default directions
    @(negedge clk);
    start = 1'b1; numPoints = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset valid", 32'(busIf.out_valid), 32'h0);
    checkOutput("midreset busy", 32'(busy), 32'h0);
    checkOutput("midreset done", 32'(done), 32'h0);
    checkOutput("midreset idx", 32'(busIf.idx_out), 32'h0);
    rst_n = 1'b1;
    runTwo("postreset", seqU[BASE], seqU[BASE+1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
